// File: rtl/tlul_mem_arbiter_pkg.sv
// Helpers for the main-memory arbiter: host-index sizing and round-robin wrap.
package tlul_mem_arbiter_pkg;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned wrap_add(input int unsigned base, input int unsigned off,
                                           input int unsigned n);
    return (base + off) % n;
  endfunction

endpackage

// File: rtl/tlul_pkg.sv
// Minimal TL-UL channel types shared by the memory-side blocks.
// Field widths follow a 32-bit address/data TL-UL profile.
package tlul_pkg;

  localparam int unsigned TL_AW  = 32;
  localparam int unsigned TL_DW  = 32;
  localparam int unsigned TL_AIW = 8;
  localparam int unsigned TL_DIW = 1;
  localparam int unsigned TL_SZW = 2;
  localparam int unsigned TL_DBW = TL_DW / 8;

  typedef enum logic [2:0] {
    PutFullData    = 3'h0,
    PutPartialData = 3'h1,
    Get            = 3'h4
  } tl_a_op_e;

  typedef enum logic [2:0] {
    AccessAck     = 3'h0,
    AccessAckData = 3'h1
  } tl_d_op_e;

  typedef struct packed {
    logic              a_valid;
    tl_a_op_e          a_opcode;
    logic [2:0]        a_param;
    logic [TL_SZW-1:0] a_size;
    logic [TL_AIW-1:0] a_source;
    logic [TL_AW-1:0]  a_address;
    logic [TL_DBW-1:0] a_mask;
    logic [TL_DW-1:0]  a_data;
    logic              d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic              d_valid;
    tl_d_op_e          d_opcode;
    logic [2:0]        d_param;
    logic [TL_SZW-1:0] d_size;
    logic [TL_AIW-1:0] d_source;
    logic [TL_DIW-1:0] d_sink;
    logic [TL_DW-1:0]  d_data;
    logic              d_error;
    logic              a_ready;
  } tl_d2h_t;

endpackage

// File: rtl/tlul_mem_arbiter_if.sv
// Bus bundle around the arbiter: host-side TL-UL ports and the single memory-side port.
// slave = arbiter view, master = hosts/memory environment view.
interface tlul_mem_arbiter_if #(
  parameter int unsigned NumHosts = 2
);

  tlul_pkg::tl_h2d_t tl_h_i [NumHosts];
  tlul_pkg::tl_d2h_t tl_h_o [NumHosts];
  tlul_pkg::tl_h2d_t tl_d_o;
  tlul_pkg::tl_d2h_t tl_d_i;

  modport master (output tl_h_i, output tl_d_i, input tl_h_o, input tl_d_o);
  modport slave  (input tl_h_i, input tl_d_i, output tl_h_o, output tl_d_o);

endinterface

// File: rtl/tlul_arb_route_fifo.sv
// In-order routing FIFO: remembers which host owns each outstanding memory request.
// Push is refused when full and pop when empty, so callers may drive them freely.
module tlul_arb_route_fifo #(
  parameter  int unsigned Width = 1,
  parameter  int unsigned Depth = 4,
  localparam int unsigned PtrW  = $clog2(Depth),
  localparam int unsigned CntW  = $clog2(Depth + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CntW-1:0]  count_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wptr_q, rptr_q;
  logic [CntW-1:0]  count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign rdata_o = mem_q[rptr_q];
  assign count_o = count_q;

  // NOTE: storage is deliberately not reset; only entries below count_q are ever read.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + PtrW'(1);
      if (do_pop)  rptr_q <= rptr_q + PtrW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/tlul_mem_arbiter.sv
// Shares one TL-UL main-memory port between NumHosts hosts: round-robin A arbitration
// with grant lock, and in-order D steering via a routing FIFO of host indices.
module tlul_mem_arbiter
  import tlul_pkg::*;
  import tlul_mem_arbiter_pkg::*;
#(
  parameter  int unsigned NumHosts       = 2,
  parameter  int unsigned MaxOutstanding = 4,
  localparam int unsigned CntW           = $clog2(MaxOutstanding + 1)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  tlul_mem_arbiter_if.slave   bus,
  output logic                unexpected_rsp_o,
  output logic [CntW-1:0]     outstanding_o
);

  localparam int unsigned IdxW = idx_width(NumHosts);
  typedef logic [IdxW-1:0] idx_t;

  idx_t rr_q, lock_idx_q, winner, grant_idx, head_idx;
  logic lock_q, fifo_full, fifo_empty, a_fwd, a_hs, d_ready_dn, d_hs;

  // Scan downward so the lowest offset from rr_q is the last (winning) assignment.
  // NOTE: default assigned first so no path through this block can infer a latch.
  always_comb begin
    winner = rr_q;
    for (int k = NumHosts - 1; k >= 0; k--) begin
      if (bus.tl_h_i[wrap_add(32'(rr_q), k, NumHosts)].a_valid)
        winner = idx_t'(wrap_add(32'(rr_q), k, NumHosts));
    end
  end

  assign grant_idx  = lock_q ? lock_idx_q : winner;
  assign a_fwd      = bus.tl_h_i[grant_idx].a_valid & ~fifo_full;
  assign a_hs       = a_fwd & bus.tl_d_i.a_ready;
  // With nothing outstanding a stray beat is accepted and dropped rather than stalling memory.
  assign d_ready_dn = fifo_empty ? 1'b1 : bus.tl_h_i[head_idx].d_ready;
  assign d_hs       = bus.tl_d_i.d_valid & d_ready_dn;

  assign unexpected_rsp_o = bus.tl_d_i.d_valid & fifo_empty;

  always_comb begin
    bus.tl_d_o         = bus.tl_h_i[grant_idx];
    bus.tl_d_o.a_valid = a_fwd;
    bus.tl_d_o.d_ready = d_ready_dn;
  end

  always_comb begin
    for (int i = 0; i < NumHosts; i++) begin
      bus.tl_h_o[i]         = bus.tl_d_i;
      bus.tl_h_o[i].a_ready = (idx_t'(i) == grant_idx) & bus.tl_d_i.a_ready & ~fifo_full;
      bus.tl_h_o[i].d_valid = (idx_t'(i) == head_idx) & ~fifo_empty & bus.tl_d_i.d_valid;
    end
  end

  // A forwarded-but-stalled request pins the grant so a_valid/payload stay stable downstream.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q       <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
    end else if (a_hs) begin
      rr_q   <= idx_t'(wrap_add(32'(grant_idx), 1, NumHosts));
      lock_q <= 1'b0;
    end else if (a_fwd && !lock_q) begin
      lock_q     <= 1'b1;
      lock_idx_q <= grant_idx;
    end
  end

  tlul_arb_route_fifo #(
    .Width (IdxW),
    .Depth (MaxOutstanding)
  ) u_route_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (a_hs),
    .wdata_i (grant_idx),
    .pop_i   (d_hs),
    .rdata_o (head_idx),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (outstanding_o)
  );

endmodule

// File: tb/tb_tlul_mem_arbiter.sv
// Directed bench for tlul_mem_arbiter: expected responses are queued when requests are
// issued and popped when a host sees d_valid.
module tb_tlul_mem_arbiter;
  import tlul_pkg::*;

  localparam int unsigned NumHosts       = 2;
  localparam int unsigned MaxOutstanding = 4;
  localparam int unsigned CntW           = $clog2(MaxOutstanding + 1);

  typedef struct {
    int unsigned host;
    logic [31:0] data;
  } rsp_t;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            unexpected;
  logic [CntW-1:0] outstanding;

  int          tests = 0;
  int          fails = 0;
  rsp_t        exp_q [$];
  logic [31:0] mem_q [$];
  logic [31:0] haddr [NumHosts];
  int unsigned g;
  int unsigned acc;

  tlul_mem_arbiter_if #(.NumHosts(NumHosts)) bus ();

  tlul_mem_arbiter #(
    .NumHosts       (NumHosts),
    .MaxOutstanding (MaxOutstanding)
  ) dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .bus              (bus),
    .unexpected_rsp_o (unexpected),
    .outstanding_o    (outstanding)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200us");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [31:0] data_of(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    for (int i = 0; i < NumHosts; i++) begin
      bus.tl_h_i[i]          = '0;
      bus.tl_h_i[i].a_opcode = Get;
      bus.tl_h_i[i].a_size   = 2'd2;
      bus.tl_h_i[i].a_mask   = '1;
      bus.tl_h_i[i].a_source = 8'(i);
      bus.tl_h_i[i].d_ready  = 1'b1;
    end
    bus.tl_d_i          = '0;
    bus.tl_d_i.d_opcode = AccessAckData;
    bus.tl_d_i.a_ready  = 1'b1;
  endtask

  task automatic set_host(input int h, input logic v, input logic [31:0] a);
    bus.tl_h_i[h].a_valid   = v;
    bus.tl_h_i[h].a_address = a;
  endtask

  // Memory model bookkeeping: remember the address of every request it accepts.
  task automatic note_a_handshake();
    if (bus.tl_d_o.a_valid && bus.tl_d_i.a_ready) mem_q.push_back(bus.tl_d_o.a_address);
  endtask

  task automatic drive_rsp(input string tag);
    check_val({tag, "_mem_pending"}, 32'(mem_q.size() != 0), 32'd1);
    bus.tl_d_i.d_valid = 1'b1;
    bus.tl_d_i.d_data  = (mem_q.size() != 0) ? data_of(mem_q.pop_front()) : 32'h0;
  endtask

  task automatic expect_rsp(input string tag);
    rsp_t e;
    check_val({tag, "_sb_nonempty"}, 32'(exp_q.size() != 0), 32'd1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check_val({tag, "_dvalid"}, 32'(bus.tl_h_o[e.host].d_valid), 32'd1);
      check_val({tag, "_ddata"}, bus.tl_h_o[e.host].d_data, e.data);
      check_val({tag, "_other_dvalid"}, 32'(bus.tl_h_o[1 - e.host].d_valid), 32'd0);
    end
  endtask

  initial begin
    idle_inputs();
    #2;
    check_val("rst_outstanding", 32'(outstanding), 32'd0);
    check_val("rst_unexpected", 32'(unexpected), 32'd0);
    check_val("rst_a_valid", 32'(bus.tl_d_o.a_valid), 32'd0);
    check_val("rst_dvalid_h0", 32'(bus.tl_h_o[0].d_valid), 32'd0);
    check_val("rst_dvalid_h1", 32'(bus.tl_h_o[1].d_valid), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;

    // Single Get from host 0, reply one cycle later.
    set_host(0, 1'b1, 32'h100);
    #1;
    check_val("t1_a_valid", 32'(bus.tl_d_o.a_valid), 32'd1);
    check_val("t1_a_addr", bus.tl_d_o.a_address, 32'h100);
    check_val("t1_a_ready_h0", 32'(bus.tl_h_o[0].a_ready), 32'd1);
    check_val("t1_a_ready_h1", 32'(bus.tl_h_o[1].a_ready), 32'd0);
    exp_q.push_back('{host: 0, data: 32'hDEAD_BEEF});
    tick();
    set_host(0, 1'b0, 32'h100);
    #1;
    check_val("t1_outstanding_1", 32'(outstanding), 32'd1);
    bus.tl_d_i.d_valid = 1'b1;
    bus.tl_d_i.d_data  = 32'hDEAD_BEEF;
    #1;
    expect_rsp("t1_rsp");
    tick();
    bus.tl_d_i.d_valid = 1'b0;
    #1;
    check_val("t1_outstanding_0", 32'(outstanding), 32'd0);

    // Fresh reset so the pointer starts at host 0, then full contention.
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    #1;
    haddr[0] = 32'h200;
    haddr[1] = 32'h300;
    set_host(0, 1'b1, haddr[0]);
    set_host(1, 1'b1, haddr[1]);
    #1;
    for (int k = 0; k < 4; k++) begin
      g = k % 2;
      check_val($sformatf("t2_grant%0d_addr", k), bus.tl_d_o.a_address, haddr[g]);
      check_val($sformatf("t2_grant%0d_ready_win", k), 32'(bus.tl_h_o[g].a_ready), 32'd1);
      check_val($sformatf("t2_grant%0d_ready_lose", k), 32'(bus.tl_h_o[1 - g].a_ready), 32'd0);
      exp_q.push_back('{host: g, data: data_of(haddr[g])});
      note_a_handshake();
      tick();
    end
    set_host(0, 1'b0, haddr[0]);
    set_host(1, 1'b0, haddr[1]);
    #1;
    check_val("t2_outstanding_4", 32'(outstanding), 32'd4);
    for (int k = 0; k < 4; k++) begin
      drive_rsp($sformatf("t2_rsp%0d", k));
      #1;
      expect_rsp($sformatf("t2_rsp%0d", k));
      tick();
    end
    bus.tl_d_i.d_valid = 1'b0;
    #1;
    check_val("t2_outstanding_0", 32'(outstanding), 32'd0);

    // Host 1 stalled by memory for 3 cycles; host 0 must not steal the grant.
    haddr[0] = 32'h600;
    haddr[1] = 32'h500;
    bus.tl_d_i.a_ready = 1'b0;
    set_host(1, 1'b1, haddr[1]);
    for (int c = 0; c < 3; c++) begin
      if (c >= 1) set_host(0, 1'b1, haddr[0]);
      #1;
      check_val($sformatf("t3_stall%0d_a_valid", c), 32'(bus.tl_d_o.a_valid), 32'd1);
      check_val($sformatf("t3_stall%0d_addr", c), bus.tl_d_o.a_address, haddr[1]);
      check_val($sformatf("t3_stall%0d_ready_h0", c), 32'(bus.tl_h_o[0].a_ready), 32'd0);
      tick();
    end
    bus.tl_d_i.a_ready = 1'b1;
    #1;
    check_val("t3_release_addr", bus.tl_d_o.a_address, haddr[1]);
    check_val("t3_release_ready_h1", 32'(bus.tl_h_o[1].a_ready), 32'd1);
    check_val("t3_release_ready_h0", 32'(bus.tl_h_o[0].a_ready), 32'd0);
    exp_q.push_back('{host: 1, data: data_of(haddr[1])});
    note_a_handshake();
    tick();
    set_host(1, 1'b0, haddr[1]);
    #1;
    check_val("t3_next_addr", bus.tl_d_o.a_address, haddr[0]);
    check_val("t3_next_ready_h0", 32'(bus.tl_h_o[0].a_ready), 32'd1);
    exp_q.push_back('{host: 0, data: data_of(haddr[0])});
    note_a_handshake();
    tick();
    set_host(0, 1'b0, haddr[0]);
    for (int k = 0; k < 2; k++) begin
      drive_rsp($sformatf("t3_rsp%0d", k));
      #1;
      expect_rsp($sformatf("t3_rsp%0d", k));
      tick();
    end
    bus.tl_d_i.d_valid = 1'b0;

    // Memory withholds D: only MaxOutstanding requests get through.
    acc = 0;
    for (int c = 0; c < 10; c++) begin
      set_host(0, 1'b1, 32'h400 + acc * 4);
      #1;
      check_val($sformatf("t4_c%0d_ready", c), 32'(bus.tl_h_o[0].a_ready), 32'(c < 4));
      check_val($sformatf("t4_c%0d_a_valid", c), 32'(bus.tl_d_o.a_valid), 32'(c < 4));
      if (c < 4) begin
        exp_q.push_back('{host: 0, data: data_of(32'h400 + acc * 4)});
        note_a_handshake();
        acc++;
      end
      tick();
    end
    check_val("t4_outstanding_full", 32'(outstanding), 32'd4);
    drive_rsp("t4_pop1");
    #1;
    expect_rsp("t4_pop1");
    check_val("t4_full_same_cycle_ready", 32'(bus.tl_h_o[0].a_ready), 32'd0);
    tick();
    bus.tl_d_i.d_valid = 1'b0;
    set_host(0, 1'b1, 32'h400 + acc * 4);
    #1;
    check_val("t4_resume_ready", 32'(bus.tl_h_o[0].a_ready), 32'd1);
    exp_q.push_back('{host: 0, data: data_of(32'h400 + acc * 4)});
    note_a_handshake();
    acc++;
    tick();
    set_host(0, 1'b1, 32'h400 + acc * 4);
    #1;
    check_val("t4_refull_ready", 32'(bus.tl_h_o[0].a_ready), 32'd0);
    check_val("t4_refull_outstanding", 32'(outstanding), 32'd4);
    set_host(0, 1'b0, 32'h0);
    for (int k = 0; k < 4; k++) begin
      drive_rsp($sformatf("t4_drain%0d", k));
      #1;
      expect_rsp($sformatf("t4_drain%0d", k));
      tick();
    end
    bus.tl_d_i.d_valid = 1'b0;
    #1;
    check_val("t4_outstanding_0", 32'(outstanding), 32'd0);

    // Stray D beat with nothing outstanding.
    bus.tl_h_i[0].d_ready = 1'b0;
    bus.tl_h_i[1].d_ready = 1'b0;
    bus.tl_d_i.d_valid    = 1'b1;
    bus.tl_d_i.d_data     = 32'h1234_5678;
    #1;
    check_val("t5_unexpected", 32'(unexpected), 32'd1);
    check_val("t5_d_ready_dn", 32'(bus.tl_d_o.d_ready), 32'd1);
    check_val("t5_dvalid_h0", 32'(bus.tl_h_o[0].d_valid), 32'd0);
    check_val("t5_dvalid_h1", 32'(bus.tl_h_o[1].d_valid), 32'd0);
    tick();
    bus.tl_d_i.d_valid    = 1'b0;
    bus.tl_h_i[0].d_ready = 1'b1;
    bus.tl_h_i[1].d_ready = 1'b1;
    #1;
    check_val("t5_unexpected_clear", 32'(unexpected), 32'd0);
    check_val("t5_outstanding", 32'(outstanding), 32'd0);

    // Three outstanding from host 0 (pointer ends on host 1), then async reset.
    for (int c = 0; c < 3; c++) begin
      set_host(0, 1'b1, 32'h700 + c * 4);
      #1;
      note_a_handshake();
      tick();
    end
    set_host(0, 1'b0, 32'h0);
    #1;
    check_val("t6_outstanding_3", 32'(outstanding), 32'd3);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("t6_async_outstanding", 32'(outstanding), 32'd0);
    check_val("t6_async_rr", 32'(dut.rr_q), 32'd0);
    check_val("t6_async_unexpected", 32'(unexpected), 32'd0);
    exp_q.delete();
    mem_q.delete();
    tick();
    rst_n = 1'b1;
    set_host(0, 1'b1, 32'h800);
    set_host(1, 1'b1, 32'h900);
    #1;
    check_val("t6_post_rst_addr", bus.tl_d_o.a_address, 32'h800);
    check_val("t6_post_rst_ready_h0", 32'(bus.tl_h_o[0].a_ready), 32'd1);
    check_val("t6_post_rst_ready_h1", 32'(bus.tl_h_o[1].a_ready), 32'd0);
    set_host(0, 1'b0, 32'h0);
    set_host(1, 1'b0, 32'h0);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
